// File: rtl/dnn_pkg.sv
// -----------------------------------------------------------------------------
// dnn_pkg
// Shared definitions for the DNN memory loader:
//   - loader_state_e : loader FSM states
//   - FP16 field constants (exponent mask, sign bit position, +0 encoding)
//   - fp16_sanitize  : flushes zero-exponent and all-ones-exponent words to +0
// -----------------------------------------------------------------------------
package dnn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    DRAIN     = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } loader_state_e;

  localparam logic [15:0] FP16_EXP_MASK = 16'h7C00;
  localparam int          FP16_SIGN_BIT = 15;
  localparam logic [15:0] FP16_ZERO     = 16'h0000;

  // Subnormals, +/-0, Inf and NaN all become +0; the sign bit is dropped too.
  function automatic logic [15:0] fp16_sanitize(input logic [15:0] word);
    logic [15:0] exp_s;
    exp_s = word & FP16_EXP_MASK;
    if ((exp_s == 16'h0000) || (exp_s == FP16_EXP_MASK)) begin
      return FP16_ZERO;
    end else begin
      return word;
    end
  endfunction

endpackage

// File: rtl/fp16_ftz.sv
// -----------------------------------------------------------------------------
// fp16_ftz
// Combinational FP16 sanitizer. With EN=1 the word goes through fp16_sanitize;
// with EN=0 it passes bit-exact.
// Ports:
//   din  : 16-bit FP16 input word
//   dout : 16-bit sanitized (or passed-through) word
// -----------------------------------------------------------------------------
module fp16_ftz
  import dnn_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [15:0] din,
  output logic [15:0] dout
);

  // Select sanitized or raw word; no state, no latency.
  always_comb begin
    dout = din;
    if (EN) begin
      dout = fp16_sanitize(din);
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/dnn_mem_loader.sv
// -----------------------------------------------------------------------------
// dnn_mem_loader
// Writes one FP16 word per accepted valid/ready beat into the activation region
// starting at ADDR_BASE_A, checks the frame length against N_WORDS, then pulses
// eng_start and waits for eng_done.
// Optional build macro: DNN_LOADER_FTZ_EN (flush zero/all-ones exponent words
// to +0 before writing). Undefined: data is written bit-exact.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last : input stream
//   mem_we/mem_waddr/mem_wdata    : registered memory write port
//   eng_start/eng_done       : engine launch pulse / completion (level or pulse)
//   busy                     : FSM not in IDLE
//   frame_done               : one-cycle pulse after engine completion
//   err_len                  : sticky frame-length error, cleared by next frame
// -----------------------------------------------------------------------------
module dnn_mem_loader
  import dnn_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 17,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 17'h00000,
  parameter int                    N_WORDS     = 401
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [15:0]           s_data,
  input  logic                  s_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [15:0]           mem_wdata,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_len
);

  localparam int              CNT_W    = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

`ifdef DNN_LOADER_FTZ_EN
  localparam bit FTZ_EN = 1'b1;
`else
  localparam bit FTZ_EN = 1'b0;
`endif

  loader_state_e         state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  ready_s, accept_s;
  logic                  wr_en_s, err_set_s, err_clr_s, start_s, done_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [15:0]           wdata_s;
  logic                  mem_we_r, eng_start_r, busy_r, frame_done_r, err_len_r;
  logic [ADDR_WIDTH-1:0] mem_waddr_r;
  logic [15:0]           mem_wdata_r;

  fp16_ftz #(.EN(FTZ_EN)) u_ftz (
    .din  (s_data),
    .dout (wdata_s)
  );

  // Ready is a pure state decode, held low while reset is asserted.
  always_comb begin
    ready_s = 1'b0;
    if (rst && ((state_r == IDLE) || (state_r == LOAD) || (state_r == DRAIN))) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign accept_s = s_valid && ready_s;
  assign s_ready  = ready_s;

  // Next-state, word counter and write/launch/error controls.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = ADDR_BASE_A + ADDR_WIDTH'(cnt_r);
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
    start_s     = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        wr_addr_s = ADDR_BASE_A;
        if (accept_s) begin
          wr_en_s   = 1'b1;
          cnt_nxt_s = CNT_W'(1);
          err_clr_s = 1'b1;
          // A one-beat frame is always too short (N_WORDS >= 2).
          if (s_last) begin
            err_set_s = 1'b1;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          wr_en_s   = 1'b1;
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            if (s_last) begin
              state_nxt_s = START;
            end else begin
              err_set_s   = 1'b1;
              state_nxt_s = DRAIN;
            end
          end else if (s_last) begin
            // Short frame: words already written stay in memory.
            err_set_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DRAIN: begin
        if (accept_s && s_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      START: begin
        start_s     = 1'b1;
        state_nxt_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (eng_done) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      mem_we_r     <= 1'b0;
      mem_waddr_r  <= '0;
      mem_wdata_r  <= 16'h0000;
      eng_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_len_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      mem_we_r     <= wr_en_s;
      eng_start_r  <= start_s;
      busy_r       <= (state_nxt_s != IDLE);
      frame_done_r <= done_s;
      if (wr_en_s) begin
        mem_waddr_r <= wr_addr_s;
        mem_wdata_r <= wdata_s;
      end
      // Set wins over clear so a one-beat frame leaves the error flagged.
      if (err_set_s) begin
        err_len_r <= 1'b1;
      end else if (err_clr_s) begin
        err_len_r <= 1'b0;
      end
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign eng_start  = eng_start_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err_len    = err_len_r;

endmodule

// File: tb/tb_dnn_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_dnn_mem_loader
// Self-checking bench for dnn_mem_loader (N_WORDS=4, non-zero base address).
// Expected writes come from a frame-level model: a frame of L beats writes its
// first min(L, N) words at BASE+i, flags err_len iff L != N, and launches the
// engine iff L == N.
// -----------------------------------------------------------------------------
module tb_dnn_mem_loader;

  localparam int             AW   = 17;
  localparam int             N    = 4;
  localparam logic [AW-1:0]  BASE = 17'h00100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_data = 16'h0000;
  logic          s_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic          eng_start;
  logic          eng_done = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          err_len;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  logic [AW+15:0] act_q[$];
  logic [AW+15:0] exp_q[$];
  logic [15:0]    fixed_q[$];

  dnn_mem_loader #(
    .ADDR_WIDTH  (AW),
    .ADDR_BASE_A (BASE),
    .N_WORDS     (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  // Record writes and count pulses just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (mem_we) act_q.push_back({mem_waddr, mem_wdata});
    if (eng_start) start_cnt++;
    if (frame_done) done_cnt++;
  end

  function automatic logic [15:0] model(input logic [15:0] d);
`ifdef DNN_LOADER_FTZ_EN
    if (d[14:10] == 5'd0 || d[14:10] == 5'd31) return 16'h0000;
`endif
    return d;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 5))
      0: w[14:10] = 5'd0;
      1: w[14:10] = 5'd31;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat from a falling edge and hold it until accepted.
  task automatic beat(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("beat_accept_timeout", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic engine(input int s0, input int f0, input int dly);
    int n;
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("eng_start_seen", start_cnt - s0, 1);
    repeat (dly) @(negedge clk);
    eng_done = 1'b1;
    n = 0;
    while (done_cnt == f0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    eng_done = 1'b0;
    chk("frame_done_seen", done_cnt - f0, 1);
  endtask

  task automatic check_frame(input logic good, input int s0, input int f0);
    chk("wr_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) chk("wr_entry", act_q[i], exp_q[i]);
    end
    chk("err_len", err_len, !good);
    chk("start_count", start_cnt - s0, good ? 1 : 0);
    chk("done_count", done_cnt - f0, good ? 1 : 0);
    chk("busy_idle", busy, 1'b0);
    chk("ready_idle", s_ready, 1'b1);
  endtask

  task automatic run_frame(input int len);
    logic [15:0]   d;
    logic [AW-1:0] a;
    int s0, f0;
    act_q.delete(); exp_q.delete();
    s0 = start_cnt; f0 = done_cnt;
    for (int i = 0; i < len; i++) begin
      if (fixed_q.size() > 0) d = fixed_q.pop_front();
      else d = rand_word();
      beat(d, (i == len - 1));
      if (i < N) begin
        a = BASE + AW'(i);
        exp_q.push_back({a, model(d)});
      end
      if (i == 0 && len > 1) chk("err_clear", err_len, 1'b0);
    end
    @(negedge clk);
    if (len == N) engine(s0, f0, $urandom_range(0, 5));
    else repeat (3) @(negedge clk);
    check_frame(len == N, s0, f0);
  endtask

  initial begin
    logic [15:0]   nom[4];
    logic [15:0]   d;
    logic [AW-1:0] a;
    int s0, f0;
    nom[0] = 16'h3C00; nom[1] = 16'h4000; nom[2] = 16'h4200; nom[3] = 16'h4400;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_outs", {mem_we, eng_start, busy, frame_done, err_len}, 5'b0);
    chk("rst_addr_data", {mem_waddr, mem_wdata}, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", s_ready, 1'b1);

    // Nominal frame, cycle-exact.
    act_q.delete();
    s0 = start_cnt; f0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = nom[i]; s_last = (i == 3);
      @(negedge clk);
      a = BASE + AW'(i);
      chk("nom_we", mem_we, 1'b1);
      chk("nom_addr", mem_waddr, a);
      chk("nom_data", mem_wdata, model(nom[i]));
      chk("nom_no_early_start", eng_start, 1'b0);
    end
    chk("nom_ready_in_start", s_ready, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("nom_eng_start", eng_start, 1'b1);
    chk("nom_we_after_last", mem_we, 1'b0);
    chk("nom_busy", busy, 1'b1);

    // Backpressure: beat held while the engine runs.
    s_valid = 1'b1; s_data = 16'h4500; s_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", s_ready, 1'b0);
      chk("bp_no_write", mem_we, 1'b0);
      chk("bp_start_once", eng_start, 1'b0);
    end
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    chk("nom_frame_done", frame_done, 1'b1);
    chk("nom_busy_fall", busy, 1'b0);
    chk("nom_ready_back", s_ready, 1'b1);
    chk("nom_err", err_len, 1'b0);
    chk("nom_start_count", start_cnt - s0, 1);
    act_q.delete(); exp_q.delete();
    s0 = start_cnt; f0 = done_cnt;
    @(negedge clk);
    s_valid = 1'b0;
    chk("held_we", mem_we, 1'b1);
    chk("held_addr", mem_waddr, BASE);
    chk("held_data", mem_wdata, model(16'h4500));
    chk("held_frame_done_pulse", frame_done, 1'b0);
    exp_q.push_back({BASE, model(16'h4500)});
    for (int i = 1; i < N; i++) begin
      d = rand_word();
      beat(d, (i == N - 1));
      a = BASE + AW'(i);
      exp_q.push_back({a, model(d)});
    end
    @(negedge clk);
    engine(s0, f0, 0);
    check_frame(1'b1, s0, f0);

    // Length errors, then a good frame that clears err_len.
    run_frame(2);
    run_frame(6);
    run_frame(1);
    run_frame(N);

    // Special FP16 values.
    fixed_q.push_back(16'h0001); fixed_q.push_back(16'h7C00);
    fixed_q.push_back(16'h8000); fixed_q.push_back(16'h3C00);
    run_frame(N);

    // Reset with two words loaded.
    act_q.delete();
    beat(rand_word(), 1'b0);
    beat(rand_word(), 1'b0);
    s0 = start_cnt;
    rst = 1'b0;
    #1;
    chk("midrst_outs", {mem_we, eng_start, busy, frame_done, err_len}, 5'b0);
    chk("midrst_addr_data", {mem_waddr, mem_wdata}, '0);
    chk("midrst_ready", s_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_start", start_cnt - s0, 0);
    chk("midrst_idle", busy, 1'b0);
    run_frame(N);

    // Randomized frames.
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 2) == 0) run_frame(N);
      else run_frame($urandom_range(1, N + 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dnn_mem_loader.md
# dnn_mem_loader

Stream-to-memory writer that fills the activation region of the inference engine's shared memory, then launches and waits for the engine. It accepts one FP16 word per valid/ready beat, writes it at consecutive addresses starting at the activation base, checks the frame length, and issues the engine's start pulse. It sits between the host/input interface and the activation memory. It is the write side of the memory the engine reads through its address/data port.

## Interface
- ADDR_WIDTH, 17: memory address width.
- ADDR_BASE_A, 17'h00000: first activation address.
- N_WORDS, 401: words per frame; must be ≥2.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  16  FP16 word.
- s_last  in  1  final beat of frame.
- mem_we  out  1  write strobe.
- mem_waddr  out  ADDR_WIDTH  write address.
- mem_wdata  out  16  write data.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_done  in  1  engine completion; level or pulse.
- busy  out  1  frame in progress: any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the engine finishes.
- err_len  out  1  sticky frame-length error.

## Operation
- States:
  - IDLE: s_ready=1.
    - An accepted beat writes word 0, sets cnt=1 and clears err_len.
    - If that beat also has s_last=1, set err_len and stay in IDLE.
    - Otherwise go to LOAD.
  - LOAD: s_ready=1. Each accepted beat writes at ADDR_BASE_A+cnt, then cnt++.
    - Beat with cnt==N_WORDS-1 and s_last=1: go to START.
    - Beat with cnt==N_WORDS-1 and s_last=0: set err_len, go to DRAIN.
    - Beat with cnt<N_WORDS-1 and s_last=1: set err_len, go to IDLE. The partial frame stays in memory.
  - DRAIN: s_ready=1. Beats are accepted and discarded with no writes. A beat with s_last=1 returns to IDLE.
  - START: s_ready=0. Assert eng_start for exactly one cycle, go to WAIT_DONE.
  - WAIT_DONE: s_ready=0.
    - eng_done=1: pulse frame_done, go to IDLE.
    - eng_done already high on the first WAIT_DONE cycle counts as done.
- A beat is accepted when s_valid && s_ready.
- cnt is ceil(log2(N_WORDS)) bits wide. Address arithmetic is ADDR_WIDTH-bit unsigned with no wrap check; ADDR_BASE_A+N_WORDS-1 must fit in ADDR_WIDTH bits.
- The engine is started only after a correct-length frame. A frame with err_len set never produces eng_start.
- s_data is written unmodified, except as described in Configuration.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0.
- s_ready follows the state combinationally. It is 0 while rst is low and 1 in the first cycle after release.
- Write latency: mem_we, mem_waddr and mem_wdata are registered and appear exactly 1 cycle after the accepted beat. Back-to-back beats give back-to-back writes.
- eng_start is asserted in the cycle after the final write strobe, so the last word is in memory before the engine starts.
- frame_done is asserted in the cycle after eng_done is sampled. s_ready returns to 1 in that same cycle.
- Minimum frame period: N_WORDS + 2 + engine latency cycles.
- Reset asserted mid-frame: immediate return to IDLE; the pending write strobe is dropped and eng_start is not issued.

## Configuration
- DNN_LOADER_FTZ_EN defined:
  - An input word with exponent 5'b00000 is written as 16'h0000 (flush subnormals and -0 to +0).
  - An input word with exponent 5'b11111 (Inf/NaN) is written as 16'h0000.
  - This adds no latency.
- DNN_LOADER_FTZ_EN undefined: data passes through bit-exact.

## Structure
- Shared package dnn_pkg holds:
  - the loader state enum (IDLE, LOAD, DRAIN, START, WAIT_DONE);
  - FP16 field constants: exponent mask 16'h7C00, sign bit 15;
  - the FP16_ZERO constant.
- One sub-module, fp16_ftz: a combinational sanitizer used only under DNN_LOADER_FTZ_EN.

## Test plan
- Nominal frame: N_WORDS=4, data 16'h3C00,16'h4000,16'h4200,16'h4400 with s_last on beat 4 → writes to 0..3 with one-cycle latency; eng_start in the cycle after the write to addr 3; eng_done 5 cycles later → frame_done pulse, busy falls.
- Early last: s_last on beat 2 of 4 → 2 writes, err_len=1, no eng_start, s_ready stays 1. The next frame's first beat clears err_len.
- Overlong frame: 6 beats, s_last on beat 6, N_WORDS=4 → 4 writes, err_len=1, beats 5–6 dropped, no eng_start.
- Backpressure: s_valid held during WAIT_DONE → s_ready=0, no writes. The held beat is accepted the cycle after frame_done.
- Reset while cnt==2 → all outputs 0, no eng_start. After release, a full frame completes normally.
- With DNN_LOADER_FTZ_EN, input 16'h0001, 16'h7C00, 16'h8000 → 16'h0000 written each time; 16'h3C00 passes unchanged. Without the macro, all four words pass bit-exact.
